// File: rtl/ai_category_pkg.sv
// Shared widths, tag default, block-state type and field-placement helpers for the category tagger.
package ai_category_pkg;

  localparam int CAT_TAG_W     = 4;
  localparam logic [CAT_TAG_W-1:0] CAT_TAG = 4'b0100;
  localparam int CAT_MODEL_W   = 4;
  localparam int CAT_PAYLOAD_W = 24;
  localparam int CAT_DATA_W    = CAT_TAG_W + CAT_MODEL_W + CAT_PAYLOAD_W;
  localparam int PSIZE_W       = 8;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } blk_state_e;

  // out_data layout, LSB first: payload | model | tag
  function automatic int model_lsb(input int payload_w);
    return payload_w;
  endfunction

  function automatic int tag_lsb(input int payload_w, input int model_w);
    return payload_w + model_w;
  endfunction

  function automatic bit fields_fit(input int data_w, input int tag_w,
                                    input int model_w, input int payload_w);
    return data_w == tag_w + model_w + payload_w;
  endfunction

endpackage

// File: rtl/ai_category_tagger_if.sv
// Input sum stream and tagged output stream between the comparer and the scoring path.
interface ai_category_tagger_if
  import ai_category_pkg::*;
#(
  parameter int DATA_W = CAT_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/ai_category_fifo.sv
// Synchronous FIFO with register-array storage, occupancy count and a flush that empties it next cycle.
module ai_category_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W:0]    r_cnt;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (PTR_W+1)'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop)  r_rd <= r_rd + PTR_W'(1);
      r_cnt <= r_cnt + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
    end
  end

  // Storage is data only; validity is carried entirely by r_cnt.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/ai_category_tagger.sv
// Category tagger: tags each accepted sum with TAG and model index, queues it, accumulates
// per-model scores with saturation and tracks the lowest-scoring model of each pass.
module ai_category_tagger
  import ai_category_pkg::*;
#(
  parameter int               DATA_W     = CAT_DATA_W,
  parameter int               TAG_W      = CAT_TAG_W,
  parameter logic [TAG_W-1:0] TAG        = CAT_TAG,
  parameter int               MODEL_W    = CAT_MODEL_W,
  parameter int               NUM_MODELS = 16,
  parameter int               PAYLOAD_W  = CAT_PAYLOAD_W,
  parameter int               ACC_W      = 32,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_init,
  input  logic [PSIZE_W-1:0]  i_packet_size,
  ai_category_tagger_if.slave bus,
  output logic [MODEL_W-1:0]  o_best_model,
  output logic                o_best_valid,
  output logic                o_done,
  output logic                o_acc_sat
);
  localparam int MODEL_LSB = model_lsb(PAYLOAD_W);
  localparam int TAG_LSB   = tag_lsb(PAYLOAD_W, MODEL_W);
  localparam logic [MODEL_W-1:0] LAST_MODEL = MODEL_W'(NUM_MODELS - 1);

  if (!fields_fit(DATA_W, TAG_W, MODEL_W, PAYLOAD_W)) begin : g_width_err
    $error("ai_category_tagger: DATA_W must equal TAG_W+MODEL_W+PAYLOAD_W");
  end

  // MSB of the result flags overflow; the low ACC_W bits are already clamped.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [PAYLOAD_W-1:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(p);
    return s[ACC_W] ? {1'b1, {ACC_W{1'b1}}} : s;
  endfunction

  blk_state_e          r_state;
  blk_state_e          w_state_nxt;
  logic [PSIZE_W-1:0]  r_psize;
  logic [PSIZE_W-1:0]  r_beat;
  logic [MODEL_W-1:0]  r_model;
  logic [ACC_W-1:0]    r_acc;
  logic                r_acc_sat;
  logic [ACC_W-1:0]    r_best_score;
  logic [MODEL_W-1:0]  r_best_model;
  logic                r_have_best;
  logic                r_best_valid;

  logic [PAYLOAD_W-1:0] w_payload;
  logic [DATA_W-1:0]    w_push_data;
  logic [DATA_W-1:0]    w_out_data;
  logic [ACC_W:0]       w_sat;
  logic [ACC_W-1:0]     w_final;
  logic                 w_ovf;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_end;
  logic                 w_last;
  logic                 w_better;
  logic                 w_unused_in_hi;

  assign w_payload      = bus.in_data[PAYLOAD_W-1:0];
  assign w_unused_in_hi = ^bus.in_data[DATA_W-1:PAYLOAD_W];
  assign bus.in_ready   = rst & ~w_full & ~i_init;
  assign w_accept       = bus.in_valid & bus.in_ready;
  assign w_end          = (r_beat >= r_psize);
  assign w_last         = (r_model == LAST_MODEL);
  assign w_sat          = sat_add(r_acc, w_payload);
  assign w_final        = w_sat[ACC_W-1:0];
  assign w_ovf          = w_sat[ACC_W];
  assign w_better       = ~r_have_best | (w_final < r_best_score);

  always_comb begin
    w_push_data = '0;
    w_push_data[PAYLOAD_W-1:0]         = w_payload;
    w_push_data[MODEL_LSB +: MODEL_W]  = r_model;
    w_push_data[TAG_LSB +: TAG_W]      = TAG;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_init)        w_state_nxt = ST_IDLE;
    else if (w_accept) w_state_nxt = w_end ? ST_IDLE : ST_COLLECT;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // packet_size only ever acts through this register, so changes land one cycle late.
  always_ff @(posedge clk) begin
    r_psize <= i_packet_size;
  end

  always_ff @(posedge clk) begin
    if (!rst || i_init) begin
      r_beat       <= '0;
      r_model      <= '0;
      r_acc        <= '0;
      r_acc_sat    <= 1'b0;
      r_best_score <= '0;
      r_best_model <= '0;
      r_have_best  <= 1'b0;
      r_best_valid <= 1'b0;
    end else if (w_accept) begin
      r_beat    <= (w_state_nxt == ST_IDLE) ? '0 : r_beat + PSIZE_W'(1);
      r_acc_sat <= r_acc_sat | w_ovf;
      if (w_end) begin
        r_acc   <= '0;
        r_model <= w_last ? '0 : r_model + MODEL_W'(1);
        if (w_better) begin
          r_best_score <= w_final;
          r_best_model <= r_model;
        end
        r_have_best  <= ~w_last;
        r_best_valid <= w_last;
      end else begin
        r_acc <= w_final;
      end
    end
  end

  ai_category_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_init),
    .i_push  (w_accept),
    .i_data  (w_push_data),
    .i_pop   (bus.out_ready),
    .o_data  (w_out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_out_data;
  assign o_done        = w_accept & w_end & w_last;
  assign o_best_model  = r_best_model;
  assign o_best_valid  = r_best_valid;
  assign o_acc_sat     = r_acc_sat;

endmodule

// File: tb/tb_ai_category_tagger.sv
// Directed bench for ai_category_tagger with two models, 24-bit accumulators and a 4-deep FIFO.
module tb_ai_category_tagger;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic [7:0] packet_size;
  logic [3:0] best_model;
  logic       best_valid;
  logic       done;
  logic       acc_sat;

  int n_chk = 0;
  int n_err = 0;

  ai_category_tagger_if #(.DATA_W(32)) bus ();

  ai_category_tagger #(
    .DATA_W     (32),
    .TAG_W      (4),
    .TAG        (4'b0100),
    .MODEL_W    (4),
    .NUM_MODELS (2),
    .PAYLOAD_W  (24),
    .ACC_W      (24),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_init        (init),
    .i_packet_size (packet_size),
    .bus           (bus),
    .o_best_model  (best_model),
    .o_best_valid  (best_valid),
    .o_done        (done),
    .o_acc_sat     (acc_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat; ready and the done pulse are checked while the beat is presented.
  task automatic send_beat(input logic [31:0] d, input logic exp_done);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    chk("send_in_ready", 32'(bus.in_ready), 32'd1);
    chk("send_done", 32'(done), 32'(exp_done));
    tick();
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] exp_w [4];
  int          n_acc;

  initial begin
    rst = 1'b0; init = 1'b0; packet_size = 8'd2;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset held for three clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_best_valid", 32'(best_valid), 32'd0);
    chk("rst_best_model", 32'(best_model), 32'd0);
    chk("rst_acc_sat", 32'(acc_sat), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Six back-to-back sums of 5, two models of three beats
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd5;
      @(negedge clk);
      chk("s2_done", 32'(done), (i == 5) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk("s2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("s2_out_data", bus.out_data, (i - 1 < 3) ? 32'h4000_0005 : 32'h4100_0005);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("s2_last_data", bus.out_data, 32'h4100_0005);
    chk("s2_best_valid", 32'(best_valid), 32'd1);
    chk("s2_best_tie", 32'(best_model), 32'd0);
    tick();
    @(negedge clk);
    chk("s2_drained", 32'(bus.out_valid), 32'd0);
    tick();

    // Model 0 scores 30, model 1 scores 9
    repeat (3) send_beat(32'd10, 1'b0);
    @(negedge clk);
    chk("s3_mid_best_valid", 32'(best_valid), 32'd0);
    chk("s3_mid_best_model", 32'(best_model), 32'd0);
    tick();
    send_beat(32'd3, 1'b0);
    send_beat(32'd3, 1'b0);
    send_beat(32'd3, 1'b1);
    @(negedge clk);
    chk("s3_best_model", 32'(best_model), 32'd1);
    chk("s3_best_valid", 32'(best_valid), 32'd1);
    tick();
    repeat (3) send_beat(32'd10, 1'b0);
    @(negedge clk);
    chk("s3_eq_mid_model", 32'(best_model), 32'd0);
    tick();
    send_beat(32'd10, 1'b0);
    send_beat(32'd10, 1'b0);
    send_beat(32'd10, 1'b1);
    @(negedge clk);
    chk("s3_eq_best_model", 32'(best_model), 32'd0);
    chk("s3_eq_best_valid", 32'(best_valid), 32'd1);
    tick();

    // Backpressure: only four of six beats fit
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h100 + 32'(n_acc);
      @(negedge clk);
      chk("s4_in_ready", 32'(bus.in_ready), (i < 4) ? 32'd1 : 32'd0);
      if (bus.in_ready) n_acc++;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    exp_w[0] = 32'h4000_0100;
    exp_w[1] = 32'h4000_0101;
    exp_w[2] = 32'h4000_0102;
    exp_w[3] = 32'h4100_0103;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s4_drain_valid", 32'(bus.out_valid), 32'd1);
      chk("s4_drain_data", bus.out_data, exp_w[k]);
      tick();
    end
    @(negedge clk);
    chk("s4_empty", 32'(bus.out_valid), 32'd0);
    tick();

    // Restart, then saturate model 0; model 1 scores 0xFFFFFE
    init = 1'b1;
    @(negedge clk);
    chk("s5_init_blocks", 32'(bus.in_ready), 32'd0);
    tick();
    init = 1'b0;
    send_beat(32'h00FF_FFFF, 1'b0);
    @(negedge clk);
    chk("s5_no_sat_yet", 32'(acc_sat), 32'd0);
    tick();
    send_beat(32'h00FF_FFFF, 1'b0);
    @(negedge clk);
    chk("s5_sat", 32'(acc_sat), 32'd1);
    tick();
    send_beat(32'h00FF_FFFF, 1'b0);
    send_beat(32'h007F_FFFF, 1'b0);
    send_beat(32'h007F_FFFF, 1'b0);
    send_beat(32'h0000_0000, 1'b1);
    @(negedge clk);
    chk("s5_best_model", 32'(best_model), 32'd1);
    chk("s5_best_valid", 32'(best_valid), 32'd1);
    chk("s5_sat_sticky", 32'(acc_sat), 32'd1);
    tick();

    // init mid model 1 with a beat offered
    repeat (3) send_beat(32'd2, 1'b0);
    bus.out_ready = 1'b0;
    send_beat(32'h33, 1'b0);
    init = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h55;
    @(negedge clk);
    chk("s6_init_ready", 32'(bus.in_ready), 32'd0);
    chk("s6_queued", 32'(bus.out_valid), 32'd1);
    chk("s6_sat_before", 32'(acc_sat), 32'd1);
    tick();
    init = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("s6_flushed", 32'(bus.out_valid), 32'd0);
    chk("s6_best_valid", 32'(best_valid), 32'd0);
    chk("s6_sat_cleared", 32'(acc_sat), 32'd0);
    tick();
    bus.out_ready = 1'b1;
    send_beat(32'h99, 1'b0);
    @(negedge clk);
    chk("s6_next_valid", 32'(bus.out_valid), 32'd1);
    chk("s6_next_model0", bus.out_data, 32'h4000_0099);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
